id_decode_queue: RTL and testbench

Registered instruction-decode stage with a parametrised decoded-instruction queue, sitting between the fetch (IF) and execute (EX) pipeline stages. It accepts raw RV32I instruction words with their PC over a valid/ready handshake and decodes each into an `rv32i_control_word`, register indices and an illegal-instruction flag. Decoded entries are buffered in a FIFO of configurable depth so that EX back-pressure does not stall fetch immediately. It supports a pipeline flush and, optionally, RV32M decode.

---
 rtl/id_decode_queue.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_id_decode_queue.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_decode_queue.sv
// RV32I decode stage with a small FIFO of decoded entries between fetch and execute.
// Optional feature: define RV32M_EN to decode the M extension (OP with funct7 = 0000001).
package rv32i_types_pkg;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode;

  typedef enum logic [2:0] {
    beq  = 3'b000,
    bne  = 3'b001,
    blt  = 3'b100,
    bge  = 3'b101,
    bltu = 3'b110,
    bgeu = 3'b111
  } branch_funct3;

  typedef enum logic [2:0] {
    alu_add = 3'b000,
    alu_sll = 3'b001,
    alu_sra = 3'b010,
    alu_sub = 3'b011,
    alu_xor = 3'b100,
    alu_srl = 3'b101,
    alu_or  = 3'b110,
    alu_and = 3'b111
  } alu_ops;

  typedef enum logic {
    am1_rs1_out = 1'b0,
    am1_pc_out  = 1'b1
  } alumux1_sel_t;

  typedef enum logic [2:0] {
    am2_i_imm   = 3'd0,
    am2_u_imm   = 3'd1,
    am2_b_imm   = 3'd2,
    am2_s_imm   = 3'd3,
    am2_j_imm   = 3'd4,
    am2_rs2_out = 3'd5
  } alumux2_sel_t;

  typedef enum logic {
    cm_rs2_out = 1'b0,
    cm_i_imm   = 1'b1
  } cmpmux_sel_t;

  typedef enum logic [3:0] {
    rf_alu_out  = 4'd0,
    rf_br_en    = 4'd1,
    rf_u_imm    = 4'd2,
    rf_lw       = 4'd3,
    rf_pc_plus4 = 4'd4,
    rf_lb       = 4'd5,
    rf_lbu      = 4'd6,
    rf_lh       = 4'd7,
    rf_lhu      = 4'd8
  } regfilemux_sel_t;

  typedef struct packed {
    rv32i_opcode     opcode;
    alu_ops          aluop;
    branch_funct3    cmpop;
    alumux1_sel_t    alumux1_sel;
    alumux2_sel_t    alumux2_sel;
    cmpmux_sel_t     cmpmux_sel;
    regfilemux_sel_t regfilemux_sel;
    logic            load_regfile;
    logic            data_mem_read;
    logic            data_mem_write;
  } rv32i_control_word;

endpackage

module id_decode_queue
  import rv32i_types_pkg::*;
#(
  parameter int unsigned QUEUE_DEPTH = 2,
  parameter int unsigned PC_WIDTH    = 32
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 flush,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [31:0]                          in_instr,
  input  logic [PC_WIDTH-1:0]                  in_pc,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [$bits(rv32i_control_word)-1:0] out_ctrl,
  output logic [31:0]                          out_instr,
  output logic [PC_WIDTH-1:0]                  out_pc,
  output logic [4:0]                           out_rs1,
  output logic [4:0]                           out_rs2,
  output logic [4:0]                           out_rd,
  output logic                                 out_illegal,
  output logic                                 out_muldiv
);

  localparam int unsigned PtrW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(QUEUE_DEPTH) + 1;

  typedef struct packed {
    rv32i_control_word   ctrl;
    logic [31:0]         instr;
    logic [PC_WIDTH-1:0] pc;
    logic                illegal;
    logic                muldiv;
  } entry_t;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];
  assign rd     = in_instr[11:7];

  rv32i_control_word dec_ctrl;
  logic              dec_illegal;
  logic              dec_muldiv;
  logic              m_op;

  always_comb begin
    dec_ctrl        = '0;
    dec_ctrl.opcode = rv32i_opcode'(opcode);
    dec_ctrl.aluop  = alu_ops'(funct3);
    dec_ctrl.cmpop  = branch_funct3'(funct3);
    dec_illegal     = 1'b0;
    dec_muldiv      = 1'b0;
    m_op            = 1'b0;
`ifdef RV32M_EN
    m_op = (funct7 == 7'b0000001);
`endif
    case (opcode)
      op_lui: begin
        dec_ctrl.load_regfile   = 1'b1;
        dec_ctrl.regfilemux_sel = rf_u_imm;
      end
      op_auipc: begin
        dec_ctrl.alumux1_sel  = am1_pc_out;
        dec_ctrl.alumux2_sel  = am2_u_imm;
        dec_ctrl.aluop        = alu_add;
        dec_ctrl.load_regfile = 1'b1;
      end
      op_jal, op_jalr: begin
        dec_ctrl.alumux1_sel    = (opcode == op_jal) ? am1_pc_out : am1_rs1_out;
        dec_ctrl.alumux2_sel    = (opcode == op_jal) ? am2_j_imm : am2_i_imm;
        dec_ctrl.aluop          = alu_add;
        dec_ctrl.regfilemux_sel = rf_pc_plus4;
        dec_ctrl.load_regfile   = 1'b1;
      end
      op_br: begin
        dec_ctrl.alumux1_sel = am1_pc_out;
        dec_ctrl.alumux2_sel = am2_b_imm;
        dec_ctrl.aluop       = alu_add;
      end
      op_load: begin
        dec_ctrl.data_mem_read = 1'b1;
        dec_ctrl.aluop         = alu_add;
        dec_ctrl.load_regfile  = 1'b1;
        case (funct3)
          3'b000:  dec_ctrl.regfilemux_sel = rf_lb;
          3'b001:  dec_ctrl.regfilemux_sel = rf_lh;
          3'b010:  dec_ctrl.regfilemux_sel = rf_lw;
          3'b100:  dec_ctrl.regfilemux_sel = rf_lbu;
          3'b101:  dec_ctrl.regfilemux_sel = rf_lhu;
          default: dec_illegal = 1'b1;
        endcase
      end
      op_store: begin
        dec_ctrl.data_mem_write = 1'b1;
        dec_ctrl.aluop          = alu_add;
        dec_ctrl.alumux2_sel    = am2_s_imm;
        dec_illegal             = (funct3 > 3'b010);
      end
      op_imm: begin
        dec_ctrl.load_regfile = 1'b1;
        case (funct3)
          3'b010, 3'b011: begin
            dec_ctrl.cmpop          = funct3[0] ? bltu : blt;
            dec_ctrl.regfilemux_sel = rf_br_en;
            dec_ctrl.cmpmux_sel     = cm_i_imm;
          end
          3'b101:  if (funct7[5]) dec_ctrl.aluop = alu_sra;
          default: ;
        endcase
      end
      op_reg: begin
        dec_ctrl.load_regfile = 1'b1;
        dec_ctrl.alumux2_sel  = am2_rs2_out;
        if (m_op) begin
          // aluop keeps funct3; EX reads it as the mul/div sub-op
          dec_muldiv = 1'b1;
        end else begin
          dec_illegal = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
          case (funct3)
            3'b000:  if (funct7[5]) dec_ctrl.aluop = alu_sub;
            3'b101:  if (funct7[5]) dec_ctrl.aluop = alu_sra;
            3'b010, 3'b011: begin
              dec_ctrl.cmpop          = funct3[0] ? bltu : blt;
              dec_ctrl.regfilemux_sel = rf_br_en;
              dec_ctrl.cmpmux_sel     = cm_rs2_out;
            end
            default: ;
          endcase
        end
      end
      default: dec_illegal = 1'b1;
    endcase
    if (dec_illegal) begin
      dec_ctrl.load_regfile   = 1'b0;
      dec_ctrl.data_mem_read  = 1'b0;
      dec_ctrl.data_mem_write = 1'b0;
    end
    if (rd == 5'd0) dec_ctrl.load_regfile = 1'b0;
  end

  entry_t          mem_q [QUEUE_DEPTH];
  logic [PtrW-1:0] rptr_q, wptr_q;
  logic [CntW-1:0] count_q;
  entry_t          head;
  logic            push, pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(QUEUE_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign head      = mem_q[rptr_q];
  assign out_valid = (count_q != '0);
  // Pop-while-full lets fetch keep streaming at one per cycle
  assign in_ready  = (count_q < CntW'(QUEUE_DEPTH)) || (out_valid && out_ready);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < QUEUE_DEPTH; i++) mem_q[i] <= '0;
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        mem_q[wptr_q] <= '{ctrl: dec_ctrl, instr: in_instr, pc: in_pc,
                           illegal: dec_illegal, muldiv: dec_muldiv};
        wptr_q        <= ptr_inc(wptr_q);
      end
      if (pop) rptr_q <= ptr_inc(rptr_q);
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

  assign out_ctrl    = head.ctrl;
  assign out_instr   = head.instr;
  assign out_pc      = head.pc;
  assign out_rs1     = head.instr[19:15];
  assign out_rs2     = head.instr[24:20];
  assign out_rd      = head.instr[11:7];
  assign out_illegal = head.illegal;
  assign out_muldiv  = head.muldiv;

endmodule

// File: tb/tb_id_decode_queue.sv
// Self-checking bench for id_decode_queue: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_id_decode_queue;
  import rv32i_types_pkg::*;

  localparam int unsigned Depth = 2;
  localparam int unsigned PcW   = 32;
  localparam int CtrlW = $bits(rv32i_control_word);
  localparam int HW    = CtrlW + 32 + PcW + 15 + 2;
  localparam bit MEn =
`ifdef RV32M_EN
    1'b1;
`else
    1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0]      in_instr, out_instr;
  logic [PcW-1:0]   in_pc, out_pc;
  logic [CtrlW-1:0] out_ctrl;
  logic [4:0]       out_rs1, out_rs2, out_rd;
  logic             out_illegal, out_muldiv;

  rv32i_control_word oc;
  logic [HW-1:0]     act_head;
  assign oc       = rv32i_control_word'(out_ctrl);
  assign act_head = {out_ctrl, out_instr, out_pc, out_rs1, out_rs2, out_rd, out_illegal, out_muldiv};

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  id_decode_queue #(.QUEUE_DEPTH(Depth), .PC_WIDTH(PcW)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .in_pc      (in_pc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_ctrl   (out_ctrl),
    .out_instr  (out_instr),
    .out_pc     (out_pc),
    .out_rs1    (out_rs1),
    .out_rs2    (out_rs2),
    .out_rd     (out_rd),
    .out_illegal(out_illegal),
    .out_muldiv (out_muldiv)
  );

  typedef struct {
    logic [31:0]    instr;
    logic [PcW-1:0] pc;
  } item_t;

  item_t mq[$];
  logic [6:0] op_pool [10] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                               7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b1110011};

  // Reference decode built from the instruction-class rules
  function automatic logic [CtrlW+1:0] ref_decode(input logic [31:0] w);
    rv32i_control_word c;
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic bad, mul, wr;
    op  = w[6:0];
    f3  = w[14:12];
    f7  = w[31:25];
    c   = '0;
    c.opcode = rv32i_opcode'(op);
    c.aluop  = alu_ops'(f3);
    c.cmpop  = branch_funct3'(f3);
    bad = 1'b0;
    mul = 1'b0;
    wr  = 1'b0;
    if (op == op_lui) begin
      wr = 1'b1; c.regfilemux_sel = rf_u_imm;
    end else if (op == op_auipc) begin
      wr = 1'b1; c.alumux1_sel = am1_pc_out; c.alumux2_sel = am2_u_imm; c.aluop = alu_add;
    end else if (op == op_jal) begin
      wr = 1'b1; c.alumux1_sel = am1_pc_out; c.alumux2_sel = am2_j_imm; c.aluop = alu_add;
      c.regfilemux_sel = rf_pc_plus4;
    end else if (op == op_jalr) begin
      wr = 1'b1; c.aluop = alu_add; c.regfilemux_sel = rf_pc_plus4;
    end else if (op == op_br) begin
      c.alumux1_sel = am1_pc_out; c.alumux2_sel = am2_b_imm; c.aluop = alu_add;
    end else if (op == op_load) begin
      wr = 1'b1; c.data_mem_read = 1'b1; c.aluop = alu_add;
      if (f3 == 3'd0) c.regfilemux_sel = rf_lb;
      else if (f3 == 3'd1) c.regfilemux_sel = rf_lh;
      else if (f3 == 3'd2) c.regfilemux_sel = rf_lw;
      else if (f3 == 3'd4) c.regfilemux_sel = rf_lbu;
      else if (f3 == 3'd5) c.regfilemux_sel = rf_lhu;
      else bad = 1'b1;
    end else if (op == op_store) begin
      c.data_mem_write = 1'b1; c.aluop = alu_add; c.alumux2_sel = am2_s_imm;
      bad = (f3 > 3'd2);
    end else if (op == op_imm || op == op_reg) begin
      wr  = 1'b1;
      mul = (op == op_reg) && MEn && (f7 == 7'd1);
      if (op == op_reg) begin
        c.alumux2_sel = am2_rs2_out;
        bad = !mul && !(f7 == 7'h00 || f7 == 7'h20);
      end
      if (!mul) begin
        if (f3 == 3'd2 || f3 == 3'd3) begin
          c.cmpop = (f3 == 3'd2) ? blt : bltu;
          c.regfilemux_sel = rf_br_en;
          c.cmpmux_sel = (op == op_imm) ? cm_i_imm : cm_rs2_out;
        end else if (f3 == 3'd5 && f7[5]) begin
          c.aluop = alu_sra;
        end else if (f3 == 3'd0 && f7[5] && op == op_reg) begin
          c.aluop = alu_sub;
        end
      end
    end else begin
      bad = 1'b1;
    end
    c.load_regfile = wr && !bad && (w[11:7] != 5'd0);
    if (bad) begin
      c.data_mem_read  = 1'b0;
      c.data_mem_write = 1'b0;
    end
    return {c, bad, mul};
  endfunction

  function automatic logic [HW-1:0] exp_head(input logic [31:0] w, input logic [PcW-1:0] pc);
    logic [CtrlW+1:0] d;
    d = ref_decode(w);
    return {d[CtrlW+1:2], w, pc, w[19:15], w[24:20], w[11:7], d[1], d[0]};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int sel;
    w   = $urandom();
    sel = $urandom_range(0, 10);
    if (sel < 10) w[6:0] = op_pool[sel];
    if (w[6:0] == 7'b0110011) begin
      case ($urandom_range(0, 3))
        0:       w[31:25] = 7'h00;
        1:       w[31:25] = 7'h20;
        2:       w[31:25] = 7'h01;
        default: ;
      endcase
    end
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = 32'h002081B3; in_pc = 32'h1234;
    tick();
    tick();
    rst = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    tests_run++;
    if (act_head !== '0) begin
      tests_failed++; $display("FAIL reset_outputs: got %h expected 0", act_head);
    end
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00812283; in_pc = 32'h40;
    tick();
    rst = 1'b1; flush = 1'b1;
    tick();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || act_head !== '0) begin
      tests_failed++;
      $display("FAIL reset_mid: got valid %b head %h expected valid 0 head 0", out_valid, act_head);
    end
  endtask

  task automatic test_decode_sequence();
    out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h002081B3; in_pc = 32'h100;
    tick();
    in_instr = 32'h402081B3; in_pc = 32'h104;
    #1;
    tests_run++;
    if (out_valid !== 1'b1) begin
      tests_failed++; $display("FAIL add_latency: got out_valid %b expected 1", out_valid);
    end
    tests_run++;
    if (oc.aluop !== alu_add || out_rs1 !== 5'd1 || out_rs2 !== 5'd2 || out_rd !== 5'd3) begin
      tests_failed++;
      $display("FAIL add_fields: got aluop %0d rs1 %0d rs2 %0d rd %0d expected 0 1 2 3",
               oc.aluop, out_rs1, out_rs2, out_rd);
    end
    tests_run++;
    if (act_head !== exp_head(32'h002081B3, 32'h100)) begin
      tests_failed++;
      $display("FAIL add_head: got %h expected %h", act_head, exp_head(32'h002081B3, 32'h100));
    end
    tick();
    in_instr = 32'h00812283; in_pc = 32'h108;
    #1;
    tests_run++;
    if (oc.aluop !== alu_sub || out_pc !== 32'h104) begin
      tests_failed++;
      $display("FAIL sub_aluop: got aluop %0d pc %h expected %0d pc 104", oc.aluop, out_pc, alu_sub);
    end
    tick();
    in_valid = 1'b0;
    #1;
    tests_run++;
    if (oc.data_mem_read !== 1'b1 || oc.regfilemux_sel !== rf_lw || out_rd !== 5'd5) begin
      tests_failed++;
      $display("FAIL lw_fields: got read %b rfmux %0d rd %0d expected 1 %0d 5",
               oc.data_mem_read, oc.regfilemux_sel, out_rd, rf_lw);
    end
    tick();
  endtask

  task automatic test_x0_illegal();
    out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h00000013; in_pc = 32'h200;
    tick();
    in_instr = 32'hFFFFFFFF; in_pc = 32'h204;
    #1;
    tests_run++;
    if (oc.load_regfile !== 1'b0 || out_illegal !== 1'b0 || out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL addi_x0: got load %b illegal %b valid %b expected 0 0 1",
               oc.load_regfile, out_illegal, out_valid);
    end
    tick();
    in_valid = 1'b0;
    #1;
    tests_run++;
    if (out_illegal !== 1'b1 ||
        {oc.load_regfile, oc.data_mem_read, oc.data_mem_write} !== 3'b000) begin
      tests_failed++;
      $display("FAIL illegal_word: got illegal %b enables %b expected 1 000", out_illegal,
               {oc.load_regfile, oc.data_mem_read, oc.data_mem_write});
    end
    tick();
  endtask

  task automatic test_back_pressure();
    logic [31:0] a, b, c;
    a = 32'h00A00093; b = 32'h0020C133; c = 32'h00112223;
    out_ready = 1'b0; in_valid = 1'b1; in_instr = a; in_pc = 32'h300;
    tick();
    in_instr = b; in_pc = 32'h304;
    tick();
    in_instr = c; in_pc = 32'h308;
    #1;
    tests_run++;
    if (in_ready !== 1'b0) begin
      tests_failed++; $display("FAIL bp_full_ready: got %b expected 0", in_ready);
    end
    out_ready = 1'b1;
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++; $display("FAIL bp_pop_ready: got %b expected 1", in_ready);
    end
    tests_run++;
    if (act_head !== exp_head(a, 32'h300)) begin
      tests_failed++; $display("FAIL bp_head_a: got %h expected %h", act_head, exp_head(a, 32'h300));
    end
    tick();
    in_valid = 1'b0;
    #1;
    tests_run++;
    if (act_head !== exp_head(b, 32'h304)) begin
      tests_failed++; $display("FAIL bp_head_b: got %h expected %h", act_head, exp_head(b, 32'h304));
    end
    tick();
    tests_run++;
    if (act_head !== exp_head(c, 32'h308) || out_valid !== 1'b1) begin
      tests_failed++; $display("FAIL bp_head_c: got %h expected %h", act_head, exp_head(c, 32'h308));
    end
    tick();
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL bp_drained: got out_valid %b expected 0", out_valid);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00100093; in_pc = 32'h400;
    tick();
    in_instr = 32'h00200113; in_pc = 32'h404;
    tick();
    flush = 1'b1; out_ready = 1'b1; in_instr = 32'h00300193; in_pc = 32'h408;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL flush_empty: got valid %b ready %b expected 0 1", out_valid, in_ready);
    end
    tick();
    tick();
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL flush_dropped: got out_valid %b expected 0", out_valid);
    end
  endtask

  task automatic test_mdecode();
    out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h022081B3; in_pc = 32'h500;
    tick();
    in_valid = 1'b0;
    #1;
    tests_run++;
`ifdef RV32M_EN
    if (out_muldiv !== 1'b1 || out_illegal !== 1'b0 || oc.load_regfile !== 1'b1) begin
      tests_failed++;
      $display("FAIL mul_decode: got muldiv %b illegal %b load %b expected 1 0 1",
               out_muldiv, out_illegal, oc.load_regfile);
    end
`else
    if (out_muldiv !== 1'b0 || out_illegal !== 1'b1 || oc.load_regfile !== 1'b0) begin
      tests_failed++;
      $display("FAIL mul_decode: got muldiv %b illegal %b load %b expected 0 1 0",
               out_muldiv, out_illegal, oc.load_regfile);
    end
`endif
    tests_run++;
    if (act_head !== exp_head(32'h022081B3, 32'h500)) begin
      tests_failed++;
      $display("FAIL mul_head: got %h expected %h", act_head, exp_head(32'h022081B3, 32'h500));
    end
    tick();
  endtask

  task automatic test_random();
    item_t it;
    bit    exp_ready;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    tick();
    rst = 1'b0;
    mq.delete();
    for (int cyc = 0; cyc < 800; cyc++) begin
      rst       = ($urandom_range(0, 99) == 0);
      flush     = ($urandom_range(0, 29) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_instr  = rand_instr();
      in_pc     = $urandom();
      #1;
      exp_ready = (mq.size() < Depth) || (mq.size() != 0 && out_ready);
      tests_run++;
      if (out_valid !== (mq.size() != 0)) begin
        tests_failed++;
        $display("FAIL rand_valid cyc %0d: got %b expected %b", cyc, out_valid, mq.size() != 0);
      end
      if (mq.size() != 0) begin
        tests_run++;
        if (act_head !== exp_head(mq[0].instr, mq[0].pc)) begin
          tests_failed++;
          $display("FAIL rand_head cyc %0d: got %h expected %h", cyc, act_head,
                   exp_head(mq[0].instr, mq[0].pc));
        end
      end
      tests_run++;
      if (in_ready !== exp_ready) begin
        tests_failed++;
        $display("FAIL rand_in_ready cyc %0d: got %b expected %b", cyc, in_ready, exp_ready);
      end
      if (rst || flush) begin
        mq.delete();
      end else begin
        if (mq.size() != 0 && out_ready) void'(mq.pop_front());
        if (in_valid && exp_ready) begin
          it.instr = in_instr;
          it.pc    = in_pc;
          mq.push_back(it);
        end
      end
      tick();
    end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_decode_sequence();
    test_x0_illegal();
    test_back_pressure();
    test_flush();
    test_mdecode();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
